// File: rtl/mux_stream_pkg.sv
// Shared definitions for the streaming N-channel multiplexer.
//   mode_e : selection mode (external fixed select or round-robin)
//   DATA_W : default per-channel data width
package mux_stream_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int DATA_W = 16;

endpackage

// File: rtl/mux_stream_n_rr_arbiter.sv
// Rotating-priority arbiter.
//   req        : per-channel request
//   last       : index of the most recently granted channel; search starts at last+1
//   gnt_onehot : one-hot grant (all-zero when nothing requests)
//   gnt_idx    : index of the granted channel (0 when nothing requests)
//   gnt_any    : a grant was issued
module rr_arbiter #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  // Walk the channels starting just after 'last', wrapping modulo N_CH;
  // the first requester found wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last) + i) % N_CH;
      if (!gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel streaming multiplexer with a registered output stage.
//   clk, rst  : clock, synchronous active-high reset
//   IN_DATA   : flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   IN_VALID  : per-channel valid
//   IN_READY  : per-channel accept (combinational, one-hot or zero)
//   MODE      : 0 = fixed select via SEL, 1 = round-robin
//   SEL       : channel index used in fixed mode
//   OUT_DATA  : registered selected data
//   OUT_CH    : registered index of the producing channel
//   OUT_VALID : output register holds a word
//   OUT_READY : consumer accepts OUT_DATA
module mux_stream_n
  import mux_stream_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] IN_DATA,
  input  logic [N_CH-1:0]       IN_VALID,
  output logic [N_CH-1:0]       IN_READY,
  input  logic                  MODE,
  input  logic [SEL_W-1:0]      SEL,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic [SEL_W-1:0]      OUT_CH,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  mode_e mode;
  assign mode = mode_e'(MODE);

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;
  logic             vld_p1;
  logic [SEL_W-1:0] last;

  logic             load_en;
  logic [N_CH-1:0]  rr_onehot;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [N_CH-1:0]  fx_onehot;
  logic             fx_any;
  logic [N_CH-1:0]  gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;

  // Room in the output register: empty, or the current word leaves this cycle.
  assign load_en = !vld_p1 || OUT_READY;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req        (IN_VALID),
    .last       (last),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

  // Fixed select; an out-of-range SEL (non-power-of-two N_CH) never grants.
  always_comb begin
    fx_onehot = '0;
    fx_any    = 1'b0;
    if (int'(SEL) < N_CH) begin
      if (IN_VALID[SEL]) begin
        fx_any         = 1'b1;
        fx_onehot[SEL] = 1'b1;
      end
    end
  end

  // Mode mux; grants are suppressed while the output stage is stalled or in reset.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    if (load_en && !rst) begin
      if (mode == MODE_RR) begin
        gnt_onehot = rr_onehot;
        gnt_idx    = rr_idx;
        gnt_any    = rr_any;
      end else begin
        gnt_onehot = fx_onehot;
        gnt_idx    = SEL;
        gnt_any    = fx_any;
      end
    end
  end

  assign IN_READY = gnt_onehot;

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      last    <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      if (gnt_any) begin
        vld_p1  <= 1'b1;
        data_p1 <= IN_DATA[gnt_idx*WIDTH +: WIDTH];
        ch_p1   <= gnt_idx;
        if (mode == MODE_RR) begin
          last <= gnt_idx;
        end
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign OUT_DATA  = data_p1;
  assign OUT_CH    = ch_p1;
  assign OUT_VALID = vld_p1;

endmodule

// File: tb/tb_mux_stream_n.sv
module tb_mux_stream_n;

  localparam int WIDTH = 16;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  logic                  clk;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  int total = 0;
  int bad   = 0;

  mux_stream_n #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .IN_DATA   (in_data),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .MODE      (mode),
    .SEL       (sel),
    .OUT_DATA  (out_data),
    .OUT_CH    (out_ch),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [SEL_W-1:0] c,
                         input logic [WIDTH-1:0] d);
    chk({tag, ".vld"},  32'(out_valid), 32'(v));
    chk({tag, ".ch"},   32'(out_ch),    32'(c));
    chk({tag, ".data"}, 32'(out_data),  32'(d));
  endtask

  task automatic chk_rdy(input string tag, input logic [N_CH-1:0] r);
    #1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'(r));
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
    in_data[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    tick();
    chk_rdy("rst_rdy", 4'b0000);
    tick();
    chk_out("rst_state", 1'b0, 2'd0, 16'h0000);

    // Load ABCD and hold it, then reset mid-stream.
    rst       = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    set_ch(0, 16'hABCD);
    chk_rdy("fill_rdy", 4'b0001);
    tick();
    chk_out("fill", 1'b1, 2'd0, 16'hABCD);
    chk_rdy("full_stall_rdy", 4'b0000);
    rst = 1'b1;
    tick();
    chk_out("midrst", 1'b0, 2'd0, 16'h0000);
    rst = 1'b0;

    // Round-robin, all channels valid: 0,1,2,3,0,1.
    for (int k = 0; k < N_CH; k++) set_ch(k, 16'h1000 + 16'(k));
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    chk_rdy("rr_first_rdy", 4'b0001);
    tick(); chk_out("rr0", 1'b1, 2'd0, 16'h1000);
    tick(); chk_out("rr1", 1'b1, 2'd1, 16'h1001);
    tick(); chk_out("rr2", 1'b1, 2'd2, 16'h1002);
    tick(); chk_out("rr3", 1'b1, 2'd3, 16'h1003);
    tick(); chk_out("rr4", 1'b1, 2'd0, 16'h1000);
    tick(); chk_out("rr5", 1'b1, 2'd1, 16'h1001);

    // Sparse requests 1010 with LAST=1: 3,1,3,1.
    in_valid = 4'b1010;
    chk_rdy("sparse_rdy", 4'b1000);
    tick(); chk_out("sp0", 1'b1, 2'd3, 16'h1003);
    tick(); chk_out("sp1", 1'b1, 2'd1, 16'h1001);
    tick(); chk_out("sp2", 1'b1, 2'd3, 16'h1003);
    tick(); chk_out("sp3", 1'b1, 2'd1, 16'h1001);

    // Backpressure holding channel 1, then same-cycle reload from channel 2.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    chk_rdy("bp_rdy", 4'b0000);
    tick(); chk_out("bp0", 1'b1, 2'd1, 16'h1001);
    tick(); chk_out("bp1", 1'b1, 2'd1, 16'h1001);
    tick(); chk_out("bp2", 1'b1, 2'd1, 16'h1001);
    chk_rdy("bp_end_rdy", 4'b0000);
    out_ready = 1'b1;
    chk_rdy("reload_rdy", 4'b0100);
    tick(); chk_out("reload", 1'b1, 2'd2, 16'h1002);

    // Switch to fixed SEL=0 with LAST=2, then back to round-robin -> channel 3.
    mode = 1'b0;
    sel  = 2'd0;
    chk_rdy("sw_fixed_rdy", 4'b0001);
    tick(); chk_out("sw_fx0", 1'b1, 2'd0, 16'h1000);
    tick(); chk_out("sw_fx1", 1'b1, 2'd0, 16'h1000);
    mode = 1'b1;
    chk_rdy("sw_rr_rdy", 4'b1000);
    tick(); chk_out("sw_rr", 1'b1, 2'd3, 16'h1003);

    // Fixed SEL=2 repeated; LAST (now 3) must not move.
    mode = 1'b0;
    sel  = 2'd2;
    set_ch(2, 16'h1234);
    chk_rdy("fx2_rdy", 4'b0100);
    tick(); chk_out("fx2a", 1'b1, 2'd2, 16'h1234);
    chk_rdy("fx2_rdy_again", 4'b0100);
    tick(); chk_out("fx2b", 1'b1, 2'd2, 16'h1234);
    mode = 1'b1;
    chk_rdy("last_kept_rdy", 4'b0001);

    // Fixed select on an idle channel: no grant, register drains.
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b1101;
    chk_rdy("idle_rdy", 4'b0000);
    tick(); chk("idle_vld0", 32'(out_valid), 32'd0);
    chk_rdy("idle_rdy2", 4'b0000);
    tick(); chk("idle_vld1", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
